// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: ALU results take the register-file write port, load returns queue and drain into idle slots.
// Optional macro WB_LOAD_BYPASS_EN lets a load that meets an empty FIFO and an idle port skip the queue.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  input  logic [4:0]  query_reg,
  output logic        query_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic alu_wr, ld_acc, bypass, enq, pop, head_wr;

  assign alu_wr   = alu_valid && (alu_reg != 5'd0);
  assign ld_ready = rst_n && (count < DEPTH_C);
  assign ld_acc   = ld_valid && ld_ready;
  assign pop      = !alu_wr && (count != '0);
`ifdef WB_LOAD_BYPASS_EN
  assign bypass   = ld_acc && (count == '0) && !alu_wr;
`else
  assign bypass   = 1'b0;
`endif
  assign enq      = ld_acc && !bypass;
  assign head_wr  = q_live[head] && (q_reg[head] != 5'd0);

  always_comb begin
    query_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i] && (q_reg[i] == query_reg) && (query_reg != 5'd0))
        query_pending = 1'b1;
    end
  end

  // Stage p0: write-slot selection
  logic        wr_en_p0;
  logic [4:0]  wr_reg_p0;
  logic [31:0] wr_data_p0;

  always_comb begin
    wr_en_p0   = 1'b0;
    wr_reg_p0  = write_reg;
    wr_data_p0 = write_data;
    if (alu_wr) begin
      wr_en_p0   = 1'b1;
      wr_reg_p0  = alu_reg;
      wr_data_p0 = alu_data;
    end else if (pop) begin
      wr_en_p0   = head_wr;
      wr_reg_p0  = q_reg[head];
      wr_data_p0 = q_data[head];
    end else if (bypass) begin
      wr_en_p0   = (ld_reg != 5'd0);
      wr_reg_p0  = ld_reg;
      wr_data_p0 = ld_data;
    end
  end

  // Queue control; an ALU write kills older queued loads to the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_wr && (q_reg[i] == alu_reg))
          q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (enq) begin
        q_live[tail] <= !(alu_wr && (ld_reg == alu_reg));
        tail         <= tail + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_reg[tail]  <= ld_reg;
      q_data[tail] <= ld_data;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else begin
      reg_write  <= wr_en_p0;
      write_reg  <= wr_reg_p0;
      write_data <= wr_data_p0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: stimulus queues expected writes, a negedge monitor checks them.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_reg = '0;
  logic [31:0] ld_data = '0;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  query_reg = '0;
  logic        query_pending;

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .query_reg(query_reg), .query_pending(query_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.r = r;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every asserted reg_write must match the oldest expected write, including its cycle
  always @(negedge clk) begin
    if (reg_write) begin
      rf[write_reg] = write_data;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=%h at cycle %0d, required no write",
                 write_reg, write_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (write_reg !== e.r || write_data !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL wb_write: got r%0d=%h at cycle %0d, required r%0d=%h at cycle %0d",
                   write_reg, write_data, cyc, e.r, e.d, e.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ld_idx;
    int n;
    bit acc;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset state
    tick;
    tick;
    query_reg = 5'd7;
    #1;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_query", query_pending, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ld_ready", ld_ready, 1);
    tick;

    // ALU write r5, then an ALU write to r0 that must not pulse
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h0000_00AA;
    expect_wr(5'd5, 32'h0000_00AA, cyc + 1);
    tick;
    alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
    tick;
    alu_valid = 1'b0;
    tick;
    tick;

    // Single load with the port idle
    n = cyc;
    ld_valid = 1'b1; ld_reg = 5'd7; ld_data = 32'h1234_5678;
    #1;
    chk("load_ready", ld_ready, 1);
`ifdef WB_LOAD_BYPASS_EN
    expect_wr(5'd7, 32'h1234_5678, n + 1);
`else
    expect_wr(5'd7, 32'h1234_5678, n + 2);
`endif
    tick;
    ld_valid = 1'b0;
    query_reg = 5'd7;
    #1;
`ifdef WB_LOAD_BYPASS_EN
    chk("query7_queued", query_pending, 0);
`else
    chk("query7_queued", query_pending, 1);
`endif
    tick;
    chk("query7_drained", query_pending, 0);
    tick;

    // ALU busy for 6 cycles while loads r1..r4 fill the queue
    n = cyc;
    ld_idx = 1;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_reg   = 5'(10 + i);
      alu_data  = 32'hA000_0000 + 32'(i);
      expect_wr(5'(10 + i), 32'hA000_0000 + 32'(i), cyc + 1);
      ld_valid  = (ld_idx <= 4);
      ld_reg    = 5'(ld_idx);
      ld_data   = 32'hD000_0000 + 32'(ld_idx);
      #1;
      chk("fill_ld_ready", ld_ready, (i < 4) ? 1 : 0);
      acc = ld_valid && ld_ready;
      tick;
      if (acc) ld_idx++;
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    chk("full_no_same_cycle_free", ld_ready, 0);
    chk("fill_accepts", ld_idx, 5);
    for (int j = 1; j <= 4; j++)
      expect_wr(5'(j), 32'hD000_0000 + 32'(j), n + 6 + j);
    repeat (6) tick;

    // Queued load r9 killed by a later ALU write to r9
    n = cyc;
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h0000_0020;
    ld_valid  = 1'b1; ld_reg = 5'd9; ld_data = 32'h0000_0001;
    expect_wr(5'd20, 32'h0000_0020, n + 1);
    tick;
    ld_valid = 1'b0;
    alu_reg = 5'd9; alu_data = 32'h0000_0002;
    expect_wr(5'd9, 32'h0000_0002, n + 2);
    query_reg = 5'd9;
    #1;
    chk("query9_live", query_pending, 1);
    tick;
    alu_valid = 1'b0;
    #1;
    chk("query9_killed", query_pending, 0);
    tick;
    tick;

    // Same-cycle ALU and load to r3: only the ALU value lands
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h0000_0005;
    ld_valid  = 1'b1; ld_reg = 5'd3; ld_data = 32'h0000_0006;
    expect_wr(5'd3, 32'h0000_0005, cyc + 1);
    tick;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    query_reg = 5'd3;
    #1;
    chk("query3_dead", query_pending, 0);
    tick;
    tick;
    tick;

    // Reset with three queued loads and a write in flight
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_reg   = 5'(21 + i);
      alu_data  = 32'h0000_00C0 + 32'(i);
      if (i < 2) expect_wr(5'(21 + i), 32'h0000_00C0 + 32'(i), cyc + 1);
      ld_valid  = 1'b1;
      ld_reg    = 5'(1 + i);
      ld_data   = 32'h0000_00E0 + 32'(i);
      tick;
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    query_reg = 5'd1;
    #1;
    chk("pre_rst_inflight", reg_write, 1);
    chk("pre_rst_query", query_pending, 1);
    chk("pre_rst_ld_ready", ld_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg_write", reg_write, 0);
    chk("mid_rst_write_reg", write_reg, 0);
    chk("mid_rst_write_data", write_data, 0);
    chk("mid_rst_ld_ready", ld_ready, 0);
    chk("mid_rst_query", query_pending, 0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("rerelease_ld_ready", ld_ready, 1);
    chk("rerelease_query", query_pending, 0);
    repeat (8) tick;

    // Final state
    chk("sb_empty", sb.size(), 0);
    chk("rf_r9", rf[9], 32'h0000_0002);
    chk("rf_r3", rf[3], 32'h0000_0005);
    chk("rf_r7", rf[7], 32'h1234_5678);
    chk("rf_r0", rf[0], 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
